// File: rtl/exception_return_unit_if.sv
// Redirect handshake from the exception return unit to the fetch stage.
// Latency: none, this is a plain signal bundle.
// Backpressure: fetch holds redirect_ready low; the master keeps valid and pc stable until it rises.
interface exception_return_unit_if #(
  parameter int W = 32
) ();
  logic         redirect_valid;
  logic         redirect_ready;
  logic [W-1:0] redirect_pc;

  // Return unit side: offers the resume PC.
  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  // Fetch side: accepts the resume PC.
  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exception_return_unit.sv
// Return side of the interrupt mechanism: LIFO of {epc, sr, mode} pushed on jisr, popped by RFE.
// Latency: RFE at edge t -> sr_restore_we during t+1..t+2, redirect_valid from t+2, pop commits on handshake.
// Backpressure: redirect_valid/redirect_pc hold until redirect_ready; jisr cancels. Optional hwm port: EXCEPTION_RETURN_HWM_EN.
module exception_return_unit #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instruction,
  input  logic                     e,
  input  logic                     jisr,
  input  logic [W-1:0]             epc_in,
  input  logic [W-1:0]             sr_in,
  input  logic [W-1:0]             mode_in,
  exception_return_unit_if.master  redir,
  output logic [W-1:0]             sr_restore,
  output logic                     sr_restore_we,
  output logic [W-1:0]             mode_restore,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stack_full,
  output logic                     overflow,
  output logic                     underflow_err,
  output logic                     rfe_illegal,
  output logic                     busy
`ifdef EXCEPTION_RETURN_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

  typedef struct packed {
    logic [W-1:0] epc;
    logic [W-1:0] sr;
    logic [W-1:0] mode;
  } ctx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_RESTORE,
    S_REDIRECT
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  ctx_t            stack_q [DEPTH];
  ctx_t            stack_d [DEPTH];
  logic [W-1:0]    redirect_pc_q, redirect_pc_d;
  logic [W-1:0]    sr_restore_q, sr_restore_d;
  logic [W-1:0]    mode_restore_q, mode_restore_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            illegal_q, illegal_d;
`ifdef EXCEPTION_RETURN_HWM_EN
  logic [DW-1:0]   hwm_q, hwm_d;
`endif

  logic            rfe_dec;
  logic            full;
  logic            user_mode;
  logic [DW-1:0]   depth_m1;
  logic [AW-1:0]   push_idx;
  logic [AW-1:0]   top_idx;
  logic            instr_unused;

  // RFE decode and stack pointers; the middle opcode bits carry no meaning for RFE.
  assign rfe_dec      = e && (instruction[31:26] == 6'b010000) && (instruction[5:0] == 6'b011000);
  assign instr_unused = ^instruction[25:6];
  assign full         = (depth_q == DEPTH_V);
  assign user_mode    = (mode_in == W'(1));
  assign depth_m1     = depth_q - DW'(1);
  assign push_idx     = depth_q[AW-1:0];
  assign top_idx      = depth_m1[AW-1:0];

  // Return sequencer and depth bookkeeping; jisr overrides whatever the sequencer wanted.
  always_comb begin
    state_d        = state_q;
    depth_d        = depth_q;
    redirect_pc_d  = redirect_pc_q;
    sr_restore_d   = sr_restore_q;
    mode_restore_d = mode_restore_q;
    overflow_d     = overflow_q;
    underflow_d    = 1'b0;
    illegal_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A simultaneous jisr swallows the RFE entirely, including its error pulses.
        if (rfe_dec && !jisr) begin
          if (user_mode) begin
            illegal_d = 1'b1;
          end else if (depth_q == '0) begin
            underflow_d = 1'b1;
          end else begin
            state_d = S_POP;
          end
        end
      end
      S_POP: begin
        // Read the top without popping; the pop commits only on the redirect handshake.
        redirect_pc_d  = stack_q[top_idx].epc;
        sr_restore_d   = stack_q[top_idx].sr;
        mode_restore_d = stack_q[top_idx].mode;
        state_d        = S_RESTORE;
      end
      S_RESTORE: begin
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redir.redirect_ready) begin
          depth_d = depth_m1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An interrupt cancels any return in flight and stacks on top of the unpopped context.
    if (jisr) begin
      state_d = S_IDLE;
      if (full) begin
        depth_d    = depth_q;
        overflow_d = 1'b1;
      end else begin
        depth_d = depth_q + DW'(1);
      end
    end
  end

  // Context write port: one push per jisr while there is room.
  always_comb begin
    stack_d = stack_q;
    if (jisr && !full) begin
      stack_d[push_idx] = {epc_in, sr_in, mode_in};
    end
  end

`ifdef EXCEPTION_RETURN_HWM_EN
  // High-water mark follows depth upward only.
  always_comb begin
    hwm_d = hwm_q;
    if (depth_d > hwm_q) begin
      hwm_d = depth_d;
    end
  end
`endif

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      depth_q        <= '0;
      redirect_pc_q  <= '0;
      sr_restore_q   <= '0;
      mode_restore_q <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      depth_q        <= depth_d;
      redirect_pc_q  <= redirect_pc_d;
      sr_restore_q   <= sr_restore_d;
      mode_restore_q <= mode_restore_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      illegal_q      <= illegal_d;
    end
  end

  // Context storage needs no reset: depth says which entries are meaningful.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

`ifdef EXCEPTION_RETURN_HWM_EN
  // High-water mark register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

  assign redir.redirect_valid = (state_q == S_REDIRECT);
  assign redir.redirect_pc    = redirect_pc_q;
  assign sr_restore           = sr_restore_q;
  assign sr_restore_we        = (state_q == S_RESTORE);
  assign mode_restore         = mode_restore_q;
  assign depth                = depth_q;
  assign stack_full           = full;
  assign overflow             = overflow_q;
  assign underflow_err        = underflow_q;
  assign rfe_illegal          = illegal_q;
  assign busy                 = (state_q != S_IDLE);

  a_depth_bound: assert property (@(posedge clk) disable iff (rst)
    depth_q <= DEPTH_V);

  a_redirect_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_REDIRECT && !redir.redirect_ready && !jisr)
      |=> (state_q == S_REDIRECT && $stable(redirect_pc_q)));

endmodule

// File: tb/tb_exception_return_unit.sv
// Randomized bench for exception_return_unit against a queue-based context model.
// Latency: checks the fixed RFE timeline and the handshake-committed pop.
// Backpressure: stalls redirect_ready and cancels returns with jisr.
module tb_exception_return_unit;
  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instruction;
  logic          e;
  logic          jisr;
  logic [W-1:0]  epc_in;
  logic [W-1:0]  sr_in;
  logic [W-1:0]  mode_in;
  logic [W-1:0]  sr_restore;
  logic          sr_restore_we;
  logic [W-1:0]  mode_restore;
  logic [DW-1:0] depth;
  logic          stack_full;
  logic          overflow;
  logic          underflow_err;
  logic          rfe_illegal;
  logic          busy;
`ifdef EXCEPTION_RETURN_HWM_EN
  logic [DW-1:0] hwm;
`endif

  exception_return_unit_if #(.W(W)) redir ();

  exception_return_unit #(.DEPTH(DEPTH), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .e             (e),
    .jisr          (jisr),
    .epc_in        (epc_in),
    .sr_in         (sr_in),
    .mode_in       (mode_in),
    .redir         (redir.master),
    .sr_restore    (sr_restore),
    .sr_restore_we (sr_restore_we),
    .mode_restore  (mode_restore),
    .depth         (depth),
    .stack_full    (stack_full),
    .overflow      (overflow),
    .underflow_err (underflow_err),
    .rfe_illegal   (rfe_illegal),
    .busy          (busy)
`ifdef EXCEPTION_RETURN_HWM_EN
    ,
    .hwm           (hwm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] sr;
    logic [W-1:0] mode;
  } ctx_t;

  ctx_t model[$];
  bit   ovf_m;
  int   hwm_m;
  int   errors = 0;
  int   checks = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    e = 1'b0; jisr = 1'b0; instruction = 32'h0; mode_in = '0;
  endtask

  task automatic rfe_drive(input logic [W-1:0] mode);
    logic [31:0] r;
    r = $urandom;
    instruction = {6'b010000, r[19:0], 6'b011000};
    e = 1'b1;
    mode_in = mode;
  endtask

  // One interrupt entry; the model stacks it unless full, where it only raises overflow.
  task automatic push(input logic [W-1:0] pc, input logic [W-1:0] sr, input logic [W-1:0] mode);
    ctx_t c;
    c.pc = pc; c.sr = sr; c.mode = mode;
    jisr = 1'b1; epc_in = pc; sr_in = sr; mode_in = mode;
    cyc();
    jisr = 1'b0; mode_in = '0;
    if (model.size() < DEPTH) model.push_back(c); else ovf_m = 1'b1;
    if (model.size() > hwm_m) hwm_m = model.size();
    checks++; if (int'(depth) != model.size()) begin errors++; $display("FAIL push_depth: got %0d want %0d", depth, model.size()); end
    checks++; if (stack_full !== (model.size() == DEPTH)) begin errors++; $display("FAIL push_full: got %0b want %0b", stack_full, model.size() == DEPTH); end
    checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL push_overflow: got %0b want %0b", overflow, ovf_m); end
  endtask

  // Full RFE return of the model's top context, ready held low for 'stall' cycles in REDIRECT.
  task automatic do_return(input int stall);
    ctx_t exp;
    int   n;
    exp = model[$];
    n   = model.size();
    redir.redirect_ready = (stall == 0);
    rfe_drive('0);
    cyc();
    e = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ret_busy_t: got %0b want 1", busy); end
    checks++; if (sr_restore_we !== 1'b0) begin errors++; $display("FAIL ret_we_t: got %0b want 0", sr_restore_we); end
    cyc();
    checks++; if (sr_restore_we !== 1'b1) begin errors++; $display("FAIL ret_we_t1: got %0b want 1", sr_restore_we); end
    checks++; if (sr_restore !== exp.sr) begin errors++; $display("FAIL ret_sr: got %0h want %0h", sr_restore, exp.sr); end
    checks++; if (mode_restore !== exp.mode) begin errors++; $display("FAIL ret_mode: got %0h want %0h", mode_restore, exp.mode); end
    checks++; if (redir.redirect_valid !== 1'b0) begin errors++; $display("FAIL ret_valid_t1: got %0b want 0", redir.redirect_valid); end
    cyc();
    checks++; if (redir.redirect_valid !== 1'b1) begin errors++; $display("FAIL ret_valid_t2: got %0b want 1", redir.redirect_valid); end
    checks++; if (redir.redirect_pc !== exp.pc) begin errors++; $display("FAIL ret_pc: got %0h want %0h", redir.redirect_pc, exp.pc); end
    checks++; if (sr_restore_we !== 1'b0) begin errors++; $display("FAIL ret_we_t2: got %0b want 0", sr_restore_we); end
    checks++; if (int'(depth) != n) begin errors++; $display("FAIL ret_depth_pre: got %0d want %0d", depth, n); end
    for (int i = 0; i < stall; i++) begin
      cyc();
      checks++; if (redir.redirect_valid !== 1'b1 || redir.redirect_pc !== exp.pc || int'(depth) != n) begin
        errors++; $display("FAIL ret_stall: valid=%0b pc=%0h depth=%0d want 1 %0h %0d", redir.redirect_valid, redir.redirect_pc, depth, exp.pc, n);
      end
    end
    redir.redirect_ready = 1'b1;
    cyc();
    void'(model.pop_back());
    checks++; if (redir.redirect_valid !== 1'b0) begin errors++; $display("FAIL ret_valid_after: got %0b want 0", redir.redirect_valid); end
    checks++; if (int'(depth) != model.size()) begin errors++; $display("FAIL ret_depth_post: got %0d want %0d", depth, model.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ret_busy_after: got %0b want 0", busy); end
  endtask

  task automatic check_hwm(input string name);
`ifdef EXCEPTION_RETURN_HWM_EN
    checks++; if (int'(hwm) != hwm_m) begin errors++; $display("FAIL %s_hwm: got %0d want %0d", name, hwm, hwm_m); end
`else
    if (name.len() == 0) $display("hwm not built");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_in(); redir.redirect_ready = 1'b0;
    epc_in = '0; sr_in = '0;
    cyc(); cyc();
    rst = 1'b0;
    model.delete(); ovf_m = 1'b0; hwm_m = 0;
    checks++; if ({redir.redirect_valid, sr_restore_we, overflow, underflow_err, rfe_illegal, busy, stack_full} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {redir.redirect_valid, sr_restore_we, overflow, underflow_err, rfe_illegal, busy, stack_full});
    end
    checks++; if ({redir.redirect_pc, sr_restore, mode_restore} !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", {redir.redirect_pc, sr_restore, mode_restore}); end
    checks++; if (depth !== '0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
    check_hwm("reset");
  endtask

  task automatic test_single();
    push(32'h100, 32'h3, 32'h0);
    do_return(0);
  endtask

  task automatic test_nested();
    push(32'h100, $urandom, 32'h0);
    push(32'h200, $urandom, 32'h1);
    push(32'h300, $urandom, 32'h0);
    do_return(0); do_return(0); do_return(0);
    check_hwm("nested");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) push(W'(i * 32'h1000), $urandom, $urandom_range(0, 1));
    for (int i = 0; i < 4; i++) do_return(0);
    check_hwm("overflow");
    rfe_drive('0);
    cyc();
    e = 1'b0;
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_pulse: got %0b want 1", underflow_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL underflow_busy: got %0b want 0", busy); end
    cyc();
    checks++; if (underflow_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL underflow_once: got %0b/%0b want 0/0", underflow_err, busy); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pc_b;
    ctx_t c;
    pc_b = $urandom;
    push(32'h111, $urandom, 32'h0);
    push(pc_b, $urandom, 32'h0);
    redir.redirect_ready = 1'b0;
    rfe_drive('0);
    cyc(); e = 1'b0; cyc(); cyc();
    checks++; if (redir.redirect_valid !== 1'b1 || redir.redirect_pc !== pc_b) begin errors++; $display("FAIL bp_start: valid=%0b pc=%0h want 1 %0h", redir.redirect_valid, redir.redirect_pc, pc_b); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (redir.redirect_valid !== 1'b1 || redir.redirect_pc !== pc_b || depth !== DW'(2)) begin
        errors++; $display("FAIL bp_hold: valid=%0b pc=%0h depth=%0d want 1 %0h 2", redir.redirect_valid, redir.redirect_pc, depth, pc_b);
      end
    end
    c.pc = 32'h400; c.sr = $urandom; c.mode = 32'h0;
    jisr = 1'b1; epc_in = c.pc; sr_in = c.sr; mode_in = c.mode;
    cyc();
    jisr = 1'b0;
    model.push_back(c);
    if (model.size() > hwm_m) hwm_m = model.size();
    checks++; if (redir.redirect_valid !== 1'b0) begin errors++; $display("FAIL cancel_valid: got %0b want 0", redir.redirect_valid); end
    checks++; if (depth !== DW'(3) || busy !== 1'b0) begin errors++; $display("FAIL cancel_depth: depth=%0d busy=%0b want 3 0", depth, busy); end
    do_return(0); do_return(2); do_return(0);
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    ctx_t c;
    push(32'h700, $urandom, 32'h1);
    rfe_drive(32'h1);
    cyc(); e = 1'b0; mode_in = '0;
    checks++; if (rfe_illegal !== 1'b1 || busy !== 1'b0 || depth !== DW'(1)) begin errors++; $display("FAIL illegal_pulse: ill=%0b busy=%0b depth=%0d want 1 0 1", rfe_illegal, busy, depth); end
    cyc();
    checks++; if (rfe_illegal !== 1'b0) begin errors++; $display("FAIL illegal_once: got %0b want 0", rfe_illegal); end
    rfe_drive('0); e = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rfe_no_e: busy=%0b want 0", busy); end
    r = $urandom;
    instruction = {6'b010000, r[19:0], 6'b000000}; e = 1'b1;
    cyc(); clear_in();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL movs2g_decode: busy=%0b want 0", busy); end
    c.pc = $urandom; c.sr = $urandom; c.mode = 32'h0;
    rfe_drive('0);
    jisr = 1'b1; epc_in = c.pc; sr_in = c.sr;
    cyc(); clear_in();
    model.push_back(c);
    if (model.size() > hwm_m) hwm_m = model.size();
    checks++; if (busy !== 1'b0 || depth !== DW'(2)) begin errors++; $display("FAIL rfe_jisr: busy=%0b depth=%0d want 0 2", busy, depth); end
    do_return(1); do_return(0);
  endtask

  task automatic test_reset_mid();
    push(32'h500, 32'h55, 32'h0);
    redir.redirect_ready = 1'b1;
    rfe_drive('0);
    cyc(); e = 1'b0; cyc();
    checks++; if (sr_restore_we !== 1'b1) begin errors++; $display("FAIL rstmid_we: got %0b want 1", sr_restore_we); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model.delete(); ovf_m = 1'b0; hwm_m = 0;
    checks++; if ({redir.redirect_valid, sr_restore_we, overflow, underflow_err, rfe_illegal, busy} !== 6'b0) begin
      errors++; $display("FAIL rstmid_flags: got %b want 0", {redir.redirect_valid, sr_restore_we, overflow, underflow_err, rfe_illegal, busy});
    end
    checks++; if ({redir.redirect_pc, sr_restore, mode_restore} !== '0 || depth !== '0) begin errors++; $display("FAIL rstmid_data: pc=%0h depth=%0d want 0 0", redir.redirect_pc, depth); end
    check_hwm("rstmid");
    cyc();
    checks++; if (redir.redirect_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: valid=%0b busy=%0b want 0 0", redir.redirect_valid, busy); end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        push($urandom, $urandom, $urandom_range(0, 2));
      end else if (r < 8 && model.size() > 0) begin
        do_return($urandom_range(0, 3));
      end else if (model.size() == 0) begin
        rfe_drive('0);
        cyc(); e = 1'b0;
        checks++; if (underflow_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rand_underflow: uf=%0b busy=%0b want 1 0", underflow_err, busy); end
      end else begin
        rfe_drive(32'h1);
        cyc(); e = 1'b0; mode_in = '0;
        checks++; if (rfe_illegal !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rand_illegal: ill=%0b busy=%0b want 1 0", rfe_illegal, busy); end
      end
    end
    check_hwm("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_nested();
    test_overflow();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/exception_return_unit.md
Name: exception_return_unit

Overview:
- Return side of the interrupt mechanism.
- Captures the interrupted context on every jisr: return PC, status register and mode. Contexts are held in a small LIFO, so nested interrupts unwind correctly.
- On an RFE instruction in the execute phase, pops the top context. It then writes SR/mode back to the SPR file and hands the return PC to the fetch stage over a valid/ready redirect handshake.

Parameters:
- DEPTH, 4, number of nested contexts held (power of two, 2..16).
- W, 32, datapath width of PC/SR/mode.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- instruction  in  32  instruction currently in execute.
- e  in  1  execute-phase strobe; RFE is decoded only when e=1.
- jisr  in  1  interrupt taken this cycle (from interrupt controller).
- epc_in  in  W  return PC to save on jisr (already rpt-selected upstream).
- sr_in  in  W  current status register, saved on jisr.
- mode_in  in  W  current mode, saved on jisr; value 1 = user.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_valid  out  1  return PC valid.
- redirect_pc  out  W  PC to resume at.
- sr_restore  out  W  SR value to write back.
- sr_restore_we  out  1  one-cycle SPR write strobe for sr_restore/mode_restore.
- mode_restore  out  W  mode value to write back.
- depth  out  $clog2(DEPTH)+1  number of stored contexts.
- stack_full  out  1  depth==DEPTH.
- overflow  out  1  sticky: a push was dropped; cleared only by rst.
- underflow_err  out  1  one-cycle pulse: RFE with empty stack.
- rfe_illegal  out  1  one-cycle pulse: RFE decoded while mode_in==1.
- busy  out  1  state != IDLE.

Behaviour:
- RFE decode: e=1, instruction[31:26]==6'b010000 and instruction[5:0]==6'b011000. This does not collide with movs2g (funct 000000) or movg2s.
- Reset: state=IDLE, depth=0. All outputs 0: redirect_valid, redirect_pc, sr_restore, sr_restore_we, mode_restore, overflow, underflow_err, rfe_illegal. Stack contents don't care. rst mid-operation aborts any return with no pop and no redirect.
- Push on jisr=1, any state:
  - If depth<DEPTH, store {epc_in, sr_in, mode_in} at index depth; depth+1 next cycle.
  - If depth==DEPTH, drop the push, set overflow, depth unchanged.
- States:
  - IDLE.
    - RFE with mode_in==1: pulse rfe_illegal, stay IDLE.
    - RFE with depth==0: pulse underflow_err, stay IDLE.
    - Otherwise RFE moves to POP.
    - jisr in the same cycle as RFE: the push wins, the RFE is ignored, stay IDLE.
  - POP (1 cycle): latch stack[depth-1] into redirect_pc/sr_restore/mode_restore; go to RESTORE. depth is NOT decremented yet.
  - RESTORE (1 cycle): sr_restore_we=1; go to REDIRECT.
  - REDIRECT: redirect_valid=1, with redirect_pc stable until the handshake.
    - On redirect_valid && redirect_ready: depth-1 (the pop commits), go to IDLE; redirect_valid low the next cycle.
- Latency: RFE accepted at edge t. POP during t..t+1, sr_restore_we high during t+1..t+2. redirect_valid rises at t+2; with ready held high, the pop commits at edge t+3.
- jisr in POP/RESTORE/REDIRECT cancels the return:
  - State goes to IDLE, redirect_valid drops next cycle, no pop.
  - The new context is pushed on top of the unpopped one, so depth ends +1 unless full.
  - If cancelled in RESTORE, the SPR write already issued is harmless: the interrupt overwrites SR on entry.
- RFE while busy is ignored.
- sr_restore_we is never asserted outside RESTORE.
- redirect_valid never drops without the handshake, except on jisr or rst.
- depth never exceeds DEPTH and never wraps below 0.

Optional Feature:
- Macro: EXCEPTION_RETURN_HWM_EN.
- Defined:
  - Adds output port hwm (width as depth): the maximum depth reached since reset.
  - It updates on the same edge as depth. rst clears it; it is otherwise never lowered.
  - The overflow case leaves hwm at DEPTH.
- Undefined: no hwm port, no register, identical behaviour otherwise.

Test Plan:
- Reset, then single nest: rst; jisr with epc_in=0x100, sr_in=0x3, mode_in=0, then RFE with e=1, ready=1.
  - Required: sr_restore_we at t+1 with sr_restore=0x3.
  - Required: redirect_valid at t+2 with redirect_pc=0x100; depth 1->0 at t+3.
- Nested interrupts: pushes 0x100, 0x200, 0x300, then three RFEs. Required: redirect_pc order 0x300, 0x200, 0x100; depth ends 0; hwm=3 with _EN.
- Overflow and underflow, DEPTH=4:
  - Five pushes: stack_full=1, overflow=1, and the fifth push is dropped (four RFEs return to the first four PCs).
  - A further RFE on the empty stack: underflow_err pulses once, busy stays 0.
- Backpressure and cancel:
  - Hold redirect_ready=0 for 5 cycles: redirect_valid and redirect_pc are stable, depth unchanged.
  - Then jisr with epc_in=0x400: redirect_valid drops and depth +1.
  - A following RFE returns 0x400.
- Illegal and simultaneous cases:
  - RFE with mode_in=1: rfe_illegal pulse, no state change.
  - RFE in the same cycle as jisr: push only, busy=0.
- Reset mid-return: rst asserted in RESTORE. Required: all outputs 0 next cycle, depth=0, no redirect_valid.
